// File: rtl/alu_unit_if.sv
// alu_unit_if: reservation-station dispatch and result-broadcast bundle for the integer ALU
interface alu_unit_if #(
    parameter int DATA_W = 32,
    parameter int ROB_POS_W = 4
);
    logic                 alu_en;
    logic [6:0]           alu_opcode;
    logic [2:0]           alu_func3;
    logic                 alu_func1;
    logic [DATA_W-1:0]    alu_val1;
    logic [DATA_W-1:0]    alu_val2;
    logic [DATA_W-1:0]    alu_imm;
    logic [DATA_W-1:0]    alu_pc;
    logic [ROB_POS_W-1:0] alu_rob_pos;
    logic                 alu_result;
    logic [ROB_POS_W-1:0] alu_result_rob_pos;
    logic [DATA_W-1:0]    alu_result_val;
    logic                 alu_result_jump;
    logic [DATA_W-1:0]    alu_result_pc;

    modport master (
        output alu_en, alu_opcode, alu_func3, alu_func1, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos,
        input  alu_result, alu_result_rob_pos, alu_result_val, alu_result_jump, alu_result_pc
    );
    modport slave (
        input  alu_en, alu_opcode, alu_func3, alu_func1, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos,
        output alu_result, alu_result_rob_pos, alu_result_val, alu_result_jump, alu_result_pc
    );
endinterface

// File: rtl/alu_unit.sv
// alu_unit: single-cycle RV32I integer/branch/jump execute stage with registered result broadcast
module alu_unit #(
    parameter int DATA_W = 32,
    parameter int ROB_POS_W = 4
) (
    input logic clk,
    input logic rst,
    input logic rdy,
    input logic rollback,
    alu_unit_if.slave bus
);
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    logic [DATA_W-1:0] v1, v2, op2, pc4, arith, sra, val, target;
    logic [4:0] sh;
    logic lts, ltu, blt, bltu, cond, jump;

    always_comb begin
        v1 = bus.alu_val1;
        v2 = bus.alu_val2;
        op2 = (bus.alu_opcode == OP) ? v2 : bus.alu_imm;
        sh = op2[4:0];
        pc4 = bus.alu_pc + DATA_W'(4);
        lts = $signed(v1) < $signed(op2);
        ltu = v1 < op2;
        blt = $signed(v1) < $signed(v2);
        bltu = v1 < v2;
        sra = $signed(v1) >>> sh;
        case (bus.alu_func3)
            3'b000: arith = (bus.alu_opcode == OP && bus.alu_func1) ? v1 - op2 : v1 + op2;
            3'b001: arith = v1 << sh;
            3'b010: arith = {{(DATA_W-1){1'b0}}, lts};
            3'b011: arith = {{(DATA_W-1){1'b0}}, ltu};
            3'b100: arith = v1 ^ op2;
            3'b101: arith = bus.alu_func1 ? sra : v1 >> sh;
            3'b110: arith = v1 | op2;
            default: arith = v1 & op2;
        endcase
        case (bus.alu_func3)
            3'b000: cond = v1 == v2;
            3'b001: cond = v1 != v2;
            3'b100: cond = blt;
            3'b101: cond = !blt;
            3'b110: cond = bltu;
            3'b111: cond = !bltu;
            default: cond = 1'b0;
        endcase
        val = '0;
        jump = 1'b0;
        target = pc4;
        case (bus.alu_opcode)
            OP, OP_IMM: val = arith;
            LUI:        val = bus.alu_imm;
            AUIPC:      val = bus.alu_pc + bus.alu_imm;
            JAL: begin
                val = pc4;
                jump = 1'b1;
                target = bus.alu_pc + bus.alu_imm;
            end
            JALR: begin
                val = pc4;
                jump = 1'b1;
                target = (v1 + bus.alu_imm) & ~DATA_W'(1);
            end
            BRANCH: begin
                jump = cond;
                target = cond ? bus.alu_pc + bus.alu_imm : pc4;
            end
            default: ;
        endcase
    end

    // rollback only kills the valid; data registers keep stale contents
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.alu_result <= 1'b0;
            bus.alu_result_rob_pos <= '0;
            bus.alu_result_val <= '0;
            bus.alu_result_jump <= 1'b0;
            bus.alu_result_pc <= '0;
        end else if (rollback) begin
            bus.alu_result <= 1'b0;
        end else if (rdy) begin
            bus.alu_result <= bus.alu_en;
            if (bus.alu_en) begin
                bus.alu_result_rob_pos <= bus.alu_rob_pos;
                bus.alu_result_val <= val;
                bus.alu_result_jump <= jump;
                bus.alu_result_pc <= target;
            end
        end
    end
endmodule
